// File: rtl/arb4_pkg.sv
// Shared types and constants for the 4-way round-robin arbiter.
package arb4_pkg;

  localparam int unsigned N_REQ        = 4;
  localparam int unsigned SEL_W        = 2;
  localparam int unsigned CNT_W        = 8;
  localparam int unsigned MAX_HOLD_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_e;

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin winner search: first requester after ptr, wrapping back to ptr.
module rr_pick4
  import arb4_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             found
);

  logic [SEL_W-1:0] cand;

  // Walk from the farthest candidate back to ptr+1 so the nearest hit wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = N_REQ; k >= 1; k--) begin
      cand = ptr + SEL_W'(k);
      if (req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arb4_rr_ctrl.sv
// Round-robin arbiter for a shared 4:1 mux path with bounded hold time and a one-cycle gap
// between owners. gnt, sel and busy are all registered.
module arb4_rr_ctrl
  import arb4_pkg::*;
#(
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             busy
);

  localparam logic [CNT_W-1:0] HoldLast = CNT_W'(MAX_HOLD - 1);

  state_e           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;

  logic [SEL_W-1:0] pick_idx;
  logic             pick_found;

  rr_pick4 u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    unique case (state_q)
      // GAP arbitrates exactly like IDLE; it only exists to force one dead cycle.
      IDLE, GAP: begin
        gnt_d   = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
        if (pick_found) begin
          gnt_d[pick_idx] = 1'b1;
          sel_d           = pick_idx;
          busy_d          = 1'b1;
          cnt_d           = '0;
          state_d         = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Owner drop and hold expiry share one release path, so coincidence releases once.
        if (!req[sel_q] || (cnt_q == HoldLast)) begin
          gnt_d   = '0;
          busy_d  = 1'b0;
          ptr_d   = sel_q;
          state_d = GAP;
        end
      end
      default: begin
        gnt_d   = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= '1;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt  = gnt_q;
  assign sel  = sel_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_arb4_rr_ctrl.sv
// Directed bench for arb4_rr_ctrl with MAX_HOLD=8, plus a randomised phase guarded by monitors.
module tb_arb4_rr_ctrl;

  localparam int unsigned Hold  = 8;
  localparam int unsigned Bound = 3 * (Hold + 1) + 1;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic       mon_en = 1'b0;
  logic [3:0] req_prev = '0;
  int         wait_cnt [4];

  arb4_rr_ctrl #(.MAX_HOLD(Hold)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .gnt   (gnt),
    .sel   (sel),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-hot, no grant without a request at the deciding edge, and starvation bound.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (($countones(gnt) > 1) || ((gnt & ~req_prev) != 4'b0000)) begin
        errors++;
        $display("FAIL mon_grant: got gnt=%b want one-hot subset of req=%b", gnt, req_prev);
      end
      for (int i = 0; i < 4; i++) begin
        int nxt;
        nxt = (req[i] && !gnt[i]) ? wait_cnt[i] + 1 : 0;
        checks++;
        if (nxt > int'(Bound)) begin
          errors++;
          $display("FAIL mon_bound: req%0d waited %0d cycles want <= %0d", i, nxt, Bound);
        end
        wait_cnt[i] <= nxt;
      end
    end else begin
      for (int i = 0; i < 4; i++) wait_cnt[i] <= 0;
    end
    req_prev <= req;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    #3;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 4'b1111;
    #1;
    tick();
    tick();
    checks++;
    if (gnt !== 4'b0000) begin
      errors++; $display("FAIL reset_gnt: got %b want 0000", gnt);
    end
    checks++;
    if (sel !== 2'b00) begin
      errors++; $display("FAIL reset_sel: got %b want 00", sel);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b want 0", busy);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (gnt !== 4'b0001 || sel !== 2'b00 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_grant: got gnt=%b sel=%b busy=%b want 0001 00 1", gnt, sel, busy);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] exp_gnt;
    logic [1:0] exp_sel;
    do_reset();
    req = 4'b1111;
    tick();
    for (int n = 0; n < 5; n++) begin
      exp_sel = 2'(n % 4);
      exp_gnt = 4'b0001 << exp_sel;
      for (int c = 0; c < int'(Hold); c++) begin
        checks++;
        if (gnt !== exp_gnt || sel !== exp_sel) begin
          errors++;
          $display("FAIL rotation_owner: owner %0d cycle %0d got gnt=%b sel=%b want %b %b",
                   n, c, gnt, sel, exp_gnt, exp_sel);
        end
        tick();
      end
      checks++;
      if (gnt !== 4'b0000 || sel !== exp_sel || busy !== 1'b0) begin
        errors++;
        $display("FAIL rotation_gap: owner %0d got gnt=%b sel=%b busy=%b want 0000 %b 0",
                 n, gnt, sel, busy, exp_sel);
      end
      tick();
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_early_release();
    do_reset();
    req = 4'b0100;
    tick();
    checks++;
    if (gnt !== 4'b0100 || sel !== 2'b10) begin
      errors++; $display("FAIL early_grant: got gnt=%b sel=%b want 0100 10", gnt, sel);
    end
    tick();
    tick();
    req = 4'b0000;
    tick();
    checks++;
    if (gnt !== 4'b0000 || sel !== 2'b10 || busy !== 1'b0) begin
      errors++;
      $display("FAIL early_gap: got gnt=%b sel=%b busy=%b want 0000 10 0", gnt, sel, busy);
    end
    tick();
    checks++;
    if (gnt !== 4'b0000 || sel !== 2'b10) begin
      errors++; $display("FAIL early_idle: got gnt=%b sel=%b want 0000 10", gnt, sel);
    end
    // ptr is now 2, so requester 0 is found after wrapping past 3.
    req = 4'b0001;
    tick();
    checks++;
    if (gnt !== 4'b0001 || sel !== 2'b00) begin
      errors++; $display("FAIL early_regrant: got gnt=%b sel=%b want 0001 00", gnt, sel);
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_coincident();
    do_reset();
    req = 4'b0001;
    tick();
    repeat (7) tick();
    checks++;
    if (gnt !== 4'b0001) begin
      errors++; $display("FAIL coinc_hold: got gnt=%b want 0001", gnt);
    end
    req = 4'b1000;
    tick();
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || sel !== 2'b00) begin
      errors++;
      $display("FAIL coinc_gap: got gnt=%b busy=%b sel=%b want 0000 0 00", gnt, busy, sel);
    end
    tick();
    checks++;
    if (gnt !== 4'b1000 || sel !== 2'b11 || busy !== 1'b1) begin
      errors++;
      $display("FAIL coinc_next: got gnt=%b sel=%b busy=%b want 1000 11 1", gnt, sel, busy);
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_midbusy_reset();
    do_reset();
    req = 4'b0010;
    tick();
    tick();
    checks++;
    if (gnt !== 4'b0010) begin
      errors++; $display("FAIL midrst_pre: got gnt=%b want 0010", gnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (gnt !== 4'b0000 || sel !== 2'b00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async: got gnt=%b sel=%b busy=%b want 0000 00 0", gnt, sel, busy);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (gnt !== 4'b0010 || sel !== 2'b01) begin
      errors++; $display("FAIL midrst_resume: got gnt=%b sel=%b want 0010 01", gnt, sel);
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_lost_request();
    logic seen3;
    seen3 = 1'b0;
    do_reset();
    req = 4'b0001;
    tick();
    tick();
    req = 4'b1001;
    tick();
    seen3 = seen3 | gnt[3];
    tick();
    seen3 = seen3 | gnt[3];
    req = 4'b0001;
    repeat (5) begin
      tick();
      seen3 = seen3 | gnt[3];
    end
    checks++;
    if (gnt !== 4'b0000 || sel !== 2'b00) begin
      errors++; $display("FAIL lost_gap: got gnt=%b sel=%b want 0000 00", gnt, sel);
    end
    tick();
    checks++;
    if (gnt !== 4'b0001) begin
      errors++; $display("FAIL lost_regrant: got gnt=%b want 0001", gnt);
    end
    repeat (10) begin
      tick();
      seen3 = seen3 | gnt[3];
    end
    checks++;
    if (seen3 !== 1'b0) begin
      errors++; $display("FAIL lost_pulse: got gnt3 seen=%b want 0", seen3);
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_random();
    do_reset();
    req = 4'b1111;
    mon_en = 1'b1;
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(7) == 0) req[i] = ~req[i];
      end
      tick();
    end
    mon_en = 1'b0;
    req = 4'b0000;
    tick();
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    test_reset();
    test_rotation();
    test_early_release();
    test_coincident();
    test_midbusy_reset();
    test_lost_request();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arb4_rr_ctrl.md
ARB4_RR_CTRL -- requirements
Module: arb4_rr_ctrl

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 8, legal range 1..255: maximum consecutive grant cycles per ownership.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes on rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port req, input, 4 bits: req[i] high = requester i wants the shared 4:1 mux path; held high for the whole transfer.
REQ-005 The block SHALL have port gnt, output, 4 bits: one-hot grant, or all zero; registered.
REQ-006 The block SHALL have port sel, output, 2 bits: encoded index of current or last owner; drives the 4:1 mux select; registered.
REQ-007 The block SHALL have port busy, output, 1 bit: high while in BUSY state; registered.

Function
REQ-008 The block SHALL implement three states: IDLE, BUSY, GAP.
REQ-009 The block SHALL keep a 2-bit round-robin pointer ptr holding the index of the last owner.
REQ-010 The block SHALL pick the winner as the first i with req[i]=1, searching ptr+1, ptr+2, ptr+3, ptr (mod 4).
REQ-011 In IDLE with any req bit high, the block SHALL, at the next edge, set gnt to one-hot(winner), sel to the winner, busy to 1, hold_cnt to 0, and enter BUSY; grant latency is 1 cycle from the sampled req.
REQ-012 In IDLE with req=0, the block SHALL stay in IDLE with gnt=0 and sel unchanged.
REQ-013 In BUSY, the block SHALL increment an 8-bit hold_cnt each cycle.
REQ-014 In BUSY, the block SHALL ignore req changes from non-owners.
REQ-015 In BUSY, when req[sel]=0 is sampled or hold_cnt=MAX_HOLD-1, the block SHALL, at the next edge, clear gnt, clear busy, set ptr=sel, and enter GAP.
REQ-016 When owner release and hold limit coincide, the block SHALL perform exactly one release.
REQ-017 In GAP (exactly one cycle, gnt=0), the block SHALL arbitrate as in IDLE using the updated ptr, entering BUSY with a new grant or IDLE if req=0.
REQ-018 The block SHALL ensure a requester whose hold limit expired while still requesting re-competes in GAP and wins only if no other requester is active.
REQ-019 The block SHALL keep sel at the last owner whenever gnt=0, so the mux output stays stable.
REQ-020 The block SHALL never assert more than one gnt bit.
REQ-021 The block SHALL never assert gnt[i] while req[i] was low at the deciding edge.
REQ-022 The block SHALL not latch requests: a req pulse dropped before being granted is lost.
REQ-023 The block SHALL guarantee each continuously asserted requester a grant within 3*(MAX_HOLD+1)+1 cycles.

Reset
REQ-024 On rst_n=0, immediately and regardless of clk, the block SHALL set state=IDLE, gnt=4'b0000, sel=2'b00, busy=0, hold_cnt=0, ptr=2'b11 (req[0] highest priority first).
REQ-025 If reset is asserted mid-BUSY, the block SHALL abort the grant with no GAP cycle; arbitration resumes on the first edge after rst_n deasserts.

Structure
REQ-026 Shared package arb4_pkg SHALL hold the state enum (IDLE, BUSY, GAP), N_REQ=4, SEL_W=2, CNT_W=8 and default MAX_HOLD.
REQ-027 One combinational sub-module rr_pick4 (inputs req, ptr; outputs idx[1:0], found) SHALL implement REQ-010.
REQ-028 All remaining logic SHALL reside in arb4_rr_ctrl.

Verification
REQ-029 Reset check -> gnt=0000, sel=00, busy=0 during reset; req=1111 at first edge after release -> gnt=0001, sel=00 one cycle later.
REQ-030 Rotation check (MAX_HOLD=8): req=1111 held -> owners 0,1,2,3,0, each for 8 cycles, each separated by one gnt=0000 GAP cycle.
REQ-031 Early release check: req=0100 -> gnt=0100; drop req[2] after 3 grant cycles -> gnt=0000 next edge, sel stays 10, IDLE after GAP.
REQ-032 Coincident release check: owner drops req on the cycle hold_cnt=7 -> single GAP; req=1000 in GAP -> gnt=1000 next edge.
REQ-033 Mid-BUSY reset check: rst_n low while gnt=0010 -> gnt=0000, sel=00 asynchronously; after release with req=0010 -> gnt=0010 next edge.
REQ-034 Lost request check: req[3] pulsed for 2 cycles during owner 0's BUSY -> never granted; one-hot and bound assertions (REQ-020, REQ-023) hold throughout random req traffic.
